frame_tx: RTL
=============

FRAME_TX -- requirements
Module: frame_tx

Interface
REQ-001 Parameter PATTERN, default 4'b1101: preamble sent MSB first; matches the team's serial pattern detector.
REQ-002 Parameter PAT_W, default 4: preamble width in bits.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  frame request, level-sensitive; the frame begins after start falls.
REQ-006 len  input  8  payload length in bits; sampled every INIT cycle, last sample kept.
REQ-007 pay_bit  input  1  payload bit from the source; valid in any cycle where pay_req=1.
REQ-008 sout  output  1  serial line; 0 whenever sout_vld=0.
REQ-009 sout_vld  output  1  high in every cycle that sout carries a frame bit.
REQ-010 pay_req  output  1  high in each payload cycle; the source advances to its next bit after each such cycle.
REQ-011 ready  output  1  high only in IDLE.

Function
REQ-012 The FSM SHALL have exactly 5 states: IDLE, INIT, PREAMBLE, LENGTH, PAYLOAD; undefined encodings go to IDLE.
REQ-013 Outputs SHALL be combinational from the state, counters and pay_bit; all outputs not listed for a state are 0.
REQ-014 IDLE: ready=1; start=1 moves to INIT, otherwise the FSM stays in IDLE.
REQ-015 INIT: len_reg<=len every cycle; the FSM stays while start=1 and moves to PREAMBLE on start=0.
REQ-016 INIT: the bit counter SHALL be cleared to 0.
REQ-017 PREAMBLE: PAT_W cycles; sout=PATTERN[PAT_W-1-i] at cycle i; sout_vld=1.
REQ-018 After the last preamble bit, the FSM SHALL move to LENGTH and clear the bit counter.
REQ-019 LENGTH: 8 cycles; sout=len_reg[7-i], MSB first; sout_vld=1.
REQ-020 After the 8th LENGTH bit: if len_reg=0 the FSM goes to IDLE; otherwise it goes to PAYLOAD and the 8-bit down counter is loaded with len_reg.
REQ-021 PAYLOAD: sout=pay_bit, sout_vld=1, pay_req=1; the down counter decrements each cycle.
REQ-022 PAYLOAD: in the cycle where the counter equals 1, the FSM SHALL go to IDLE.
REQ-023 Frame length SHALL be PAT_W+8+len_reg cycles of sout_vld=1 with no gaps; len=255 gives 267 cycles.
REQ-024 The down counter SHALL never wrap: a load of 0 is impossible per REQ-020.
REQ-025 start SHALL be ignored in PREAMBLE, LENGTH and PAYLOAD; start high at the return to IDLE begins a new frame on the next cycle.
REQ-026 len changes after INIT SHALL NOT affect the current frame.
REQ-027 The next frame's first preamble bit SHALL come at least 2 cycles after the last payload bit (IDLE, then INIT).

Reset
REQ-028 rst=0 SHALL immediately force IDLE, bit counter=0, down counter=0, len_reg=0, independent of clk.
REQ-029 During and after reset: ready=1, sout=0, sout_vld=0, pay_req=0.
REQ-030 Reset mid-frame SHALL abort at once with no further sout_vld; the first edge after release evaluates IDLE.

Verification
REQ-031 Reset, start pulsed 1 cycle, len=3, pay_bit=1,0,1 -> sout_vld high 15 cycles; sout=1101 00000011 101; pay_req high for the last 3 cycles; ready=1 on the next cycle.
REQ-032 len=0 -> 12 valid bits, 1101 00000000; pay_req never asserted; back to IDLE.
REQ-033 start held 5 cycles, len changing 7 to 9 to 2 -> LENGTH field = 00000010; exactly 2 payload cycles.
REQ-034 len=255, pay_bit toggling -> 267 contiguous valid cycles; pay_req count = 255; counter never wraps.
REQ-035 rst=0 asserted during the 3rd LENGTH bit -> sout_vld=0 and ready=1 within the same cycle; a new frame with len=1 is correct afterward.
REQ-036 start held high through the end of a frame -> INIT entered at once; start toggling during PAYLOAD has no effect on the frame.

Source files
------------

// File: rtl/frame_tx.sv
// -----------------------------------------------------------------------------
// frame_tx
// Serial frame transmitter. A frame is a fixed preamble (PATTERN, MSB first),
// an 8-bit length field (MSB first), then len_reg payload bits pulled from the
// source one per cycle. sout_vld stays high for the whole frame with no gaps.
//
// Parameters
//   PAT_W     preamble width in bits
//   PATTERN   preamble value, sent MSB first
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   start     frame request (level); the frame begins after start falls
//   len       payload length in bits, sampled every INIT cycle
//   pay_bit   payload bit from the source, valid while pay_req=1
//   sout      serial data, 0 whenever sout_vld=0
//   sout_vld  high in every cycle sout carries a frame bit
//   pay_req   high in each payload cycle; source advances after each one
//   ready     high only in IDLE
// -----------------------------------------------------------------------------
module frame_tx #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] len,
  input  logic       pay_bit,
  output logic       sout,
  output logic       sout_vld,
  output logic       pay_req,
  output logic       ready
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] INIT     = 3'd1;
  localparam logic [2:0] PREAMBLE = 3'd2;
  localparam logic [2:0] LENGTH   = 3'd3;
  localparam logic [2:0] PAYLOAD  = 3'd4;

  localparam logic [7:0] PRE_LAST = 8'(PAT_W - 1);

  logic [2:0]       state_r,   state_s;
  logic [7:0]       bit_cnt_r, bit_cnt_s;
  logic [7:0]       down_cnt_r, down_cnt_s;
  logic [7:0]       len_r,     len_s;
  // Preamble bits are taken from the top of a shift register that is
  // reloaded from PATTERN in INIT, so no variable-width index is needed.
  logic [PAT_W-1:0] pat_sh_r,  pat_sh_s;
  logic             len_bit_s;

  // Current length-field bit, MSB first.
  always_comb begin
    len_bit_s = len_r[3'd7 - bit_cnt_r[2:0]];
  end

  // Next-state and counter logic.
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    down_cnt_s = down_cnt_r;
    len_s      = len_r;
    pat_sh_s   = pat_sh_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = INIT;
        end else begin
          state_s = IDLE;
        end
      end
      INIT: begin
        // Keep re-sampling len while start is held; the last sample wins.
        len_s     = len;
        bit_cnt_s = 8'd0;
        pat_sh_s  = PATTERN;
        if (!start) begin
          state_s = PREAMBLE;
        end else begin
          state_s = INIT;
        end
      end
      PREAMBLE: begin
        pat_sh_s = pat_sh_r << 1'b1;
        if (bit_cnt_r == PRE_LAST) begin
          state_s   = LENGTH;
          bit_cnt_s = 8'd0;
        end else begin
          bit_cnt_s = bit_cnt_r + 8'd1;
        end
      end
      LENGTH: begin
        if (bit_cnt_r == 8'd7) begin
          bit_cnt_s = 8'd0;
          if (len_r == 8'd0) begin
            state_s = IDLE;
          end else begin
            state_s    = PAYLOAD;
            down_cnt_s = len_r;
          end
        end else begin
          bit_cnt_s = bit_cnt_r + 8'd1;
        end
      end
      PAYLOAD: begin
        // Leaving at a count of 1 lands the counter on 0; a count of 0 can
        // never be loaded, but it also exits rather than wrapping.
        if (down_cnt_r <= 8'd1) begin
          state_s    = IDLE;
          down_cnt_s = 8'd0;
        end else begin
          down_cnt_s = down_cnt_r - 8'd1;
        end
      end
      default: begin
        state_s    = IDLE;
        bit_cnt_s  = 8'd0;
        down_cnt_s = 8'd0;
      end
    endcase
  end

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 8'd0;
      down_cnt_r <= 8'd0;
      len_r      <= 8'd0;
      pat_sh_r   <= '0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      down_cnt_r <= down_cnt_s;
      len_r      <= len_s;
      pat_sh_r   <= pat_sh_s;
    end
  end

  // Outputs decoded from the state; payload data passes straight through.
  always_comb begin
    sout     = 1'b0;
    sout_vld = 1'b0;
    pay_req  = 1'b0;
    ready    = 1'b0;
    case (state_r)
      IDLE: begin
        ready = 1'b1;
      end
      INIT: begin
        ready = 1'b0;
      end
      PREAMBLE: begin
        sout     = pat_sh_r[PAT_W-1];
        sout_vld = 1'b1;
      end
      LENGTH: begin
        sout     = len_bit_s;
        sout_vld = 1'b1;
      end
      PAYLOAD: begin
        sout     = pay_bit;
        sout_vld = 1'b1;
        pay_req  = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule
